// File: rtl/pcs_pkg.sv
// Shared definitions for the 1000BASE-X style code-group synchronizer.
//
// Contents:
//   - K28.5 comma constants (both running disparities) and D16.2.
//   - FSM state encoding.
//   - Code-group classification helpers used by pcs_cg_classify and
//     pcs_code_sync.
//
// Validity decode: a code-group is "valid" when its 6b sub-block (abcdei)
// has 2..4 ones, its 4b sub-block (fghj) has 1..3 ones, and the whole
// 10b group has 4..6 ones. Every legal 8b/10b code-group satisfies these
// disparity bounds. Running disparity is not tracked here.
package pcs_pkg;

    // Bit 9 is 'a', bit 0 is 'j'.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] D16_2_RDP = 10'b1001000101;

    typedef enum logic [2:0] {
        ST_LOSS_OF_SYNC  = 3'd0,
        ST_COMMA_DETECT  = 3'd1,
        ST_ACQUIRE_SYNC  = 3'd2,
        ST_SYNC_ACQUIRED = 3'd3,
        ST_SYNC_RECOVER  = 3'd4
    } sync_state_e;

    function automatic logic [3:0] ones10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic is_comma(input logic [9:0] cg);
        return (cg == K28_5_RDN) || (cg == K28_5_RDP);
    endfunction

    function automatic logic is_valid(input logic [9:0] cg);
        logic [3:0] n_hi;
        logic [3:0] n_lo;
        logic [3:0] n_all;
        n_hi  = ones10({4'd0, cg[9:4]});
        n_lo  = ones10({6'd0, cg[3:0]});
        n_all = ones10(cg);
        return (n_hi >= 4'd2) && (n_hi <= 4'd4) &&
               (n_lo >= 4'd1) && (n_lo <= 4'd3) &&
               (n_all >= 4'd4) && (n_all <= 4'd6);
    endfunction

    // Data = valid group that is not a K28.x control group. The 6b patterns
    // 001111/110000 occur only in K28.x.
    function automatic logic is_data(input logic [9:0] cg);
        return is_valid(cg) && (cg[9:4] != 6'b001111) && (cg[9:4] != 6'b110000);
    endfunction

    // A comma is only acceptable in the even position (rx_even==0 before
    // the group is consumed).
    function automatic logic cgbad(input logic valid, input logic comma,
                                   input logic rx_even);
        return !valid || (comma && rx_even);
    endfunction

    function automatic logic cggood(input logic valid, input logic comma,
                                    input logic rx_even);
        return !cgbad(valid, comma, rx_even);
    endfunction

endpackage

// File: rtl/pcs_cg_classify.sv
// Combinational code-group classifier.
//
// Ports:
//   code_group  in  10  received code-group
//   comma       out 1   K28.5, either disparity
//   data        out 1   valid non-K28 group
//   valid       out 1   group passes the disparity-bound validity check
module pcs_cg_classify
    import pcs_pkg::*;
(
    input  logic [9:0] code_group,
    output logic       comma,
    output logic       data,
    output logic       valid
);

    assign comma = is_comma(code_group);
    assign data  = is_data(code_group);
    assign valid = is_valid(code_group);

endmodule

// File: rtl/pcs_code_sync.sv
// Code-group synchronization state machine with loss-event counter.
//
// Ports:
//   clock             in  1            clock
//   reset             in  1            asynchronous reset, active low
//   rx_code_group     in  10           received code-group, one per clock
//   signal_detect     in  1            PMD signal present; 0 forces loss
//   SUDI              out 10           rx_code_group delayed one clock
//   code_sync_status  out 1            1 = synchronized
//   rx_even           out 1            even/odd position flag
//   bad_cnt           out BAD_W        accumulated bad count while synced
//   loss_events       out CNT_W        saturating count of sync losses
module pcs_code_sync
    import pcs_pkg::*;
#(
    parameter int ACQ_PAIRS  = 3,
    parameter int BAD_LIMIT  = 4,
    parameter int GOOD_LIMIT = 4,
    parameter int CNT_W      = 16,
    localparam int BAD_W     = $clog2(BAD_LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [9:0]       rx_code_group,
    input  logic             signal_detect,
    output logic [9:0]       SUDI,
    output logic             code_sync_status,
    output logic             rx_even,
    output logic [BAD_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] loss_events
);

    localparam int ACQ_W  = (ACQ_PAIRS > 1) ? $clog2(ACQ_PAIRS) : 1;
    localparam int GOOD_W = (GOOD_LIMIT > 1) ? $clog2(GOOD_LIMIT) : 1;

    localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(ACQ_PAIRS - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_LIMIT - 1);

    sync_state_e       state_q, state_d;
    logic [9:0]        sudi_q;
    logic              sync_q, sync_d;
    logic              rx_even_q, rx_even_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [ACQ_W-1:0]  acq_cnt_q, acq_cnt_d;
    logic [GOOD_W-1:0] good_cgs_q, good_cgs_d;
    logic [CNT_W-1:0]  loss_q, loss_d;

    logic cg_comma;
    logic cg_data;
    logic cg_valid;
    logic cg_bad;
    logic in_sync_q;

    pcs_cg_classify u_classify (
        .code_group (rx_code_group),
        .comma      (cg_comma),
        .data       (cg_data),
        .valid      (cg_valid)
    );

    // Classification uses the position flag as it stands before this group.
    assign cg_bad    = cgbad(cg_valid, cg_comma, rx_even_q);
    assign in_sync_q = (state_q == ST_SYNC_ACQUIRED) || (state_q == ST_SYNC_RECOVER);

    always_comb begin
        state_d    = state_q;
        rx_even_d  = ~rx_even_q;
        acq_cnt_d  = acq_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        good_cgs_d = good_cgs_q;

        if (!signal_detect) begin
            state_d    = ST_LOSS_OF_SYNC;
            acq_cnt_d  = '0;
            bad_cnt_d  = '0;
            good_cgs_d = '0;
        end else begin
            case (state_q)
                ST_LOSS_OF_SYNC: begin
                    if (cg_comma) begin
                        state_d   = ST_COMMA_DETECT;
                        rx_even_d = 1'b1;
                        acq_cnt_d = '0;
                    end
                end
                ST_COMMA_DETECT: begin
                    if (cg_data) begin
                        if (acq_cnt_q == ACQ_LAST) begin
                            state_d = ST_SYNC_ACQUIRED;
                        end else begin
                            state_d   = ST_ACQUIRE_SYNC;
                            acq_cnt_d = acq_cnt_q + ACQ_W'(1);
                        end
                    end else begin
                        state_d = ST_LOSS_OF_SYNC;
                    end
                end
                ST_ACQUIRE_SYNC: begin
                    if (!rx_even_q && cg_comma) begin
                        state_d   = ST_COMMA_DETECT;
                        rx_even_d = 1'b1;
                    end else if (cg_bad) begin
                        state_d = ST_LOSS_OF_SYNC;
                    end
                end
                ST_SYNC_ACQUIRED: begin
                    if (cg_bad) begin
                        if (BAD_LIMIT == 1) begin
                            state_d = ST_LOSS_OF_SYNC;
                        end else begin
                            state_d    = ST_SYNC_RECOVER;
                            bad_cnt_d  = BAD_W'(1);
                            good_cgs_d = '0;
                        end
                    end
                end
                ST_SYNC_RECOVER: begin
                    if (cg_bad) begin
                        good_cgs_d = '0;
                        if (bad_cnt_q == BAD_LAST) begin
                            // Counters are meaningless out of sync; clear them.
                            state_d   = ST_LOSS_OF_SYNC;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        end
                    end else if (good_cgs_q == GOOD_LAST) begin
                        good_cgs_d = '0;
                        bad_cnt_d  = bad_cnt_q - BAD_W'(1);
                        if (bad_cnt_q == BAD_W'(1)) begin
                            state_d = ST_SYNC_ACQUIRED;
                        end
                    end else begin
                        good_cgs_d = good_cgs_q + GOOD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_LOSS_OF_SYNC;
                end
            endcase
        end
    end

    // Status and loss counter follow the next state so they change on the
    // same edge as the state register.
    always_comb begin
        sync_d = (state_d == ST_SYNC_ACQUIRED) || (state_d == ST_SYNC_RECOVER);
        loss_d = loss_q;
        if (in_sync_q && (state_d == ST_LOSS_OF_SYNC) && (loss_q != {CNT_W{1'b1}})) begin
            loss_d = loss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOSS_OF_SYNC;
            sudi_q     <= '0;
            sync_q     <= 1'b0;
            rx_even_q  <= 1'b0;
            bad_cnt_q  <= '0;
            acq_cnt_q  <= '0;
            good_cgs_q <= '0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_d;
            sudi_q     <= rx_code_group;
            sync_q     <= sync_d;
            rx_even_q  <= rx_even_d;
            bad_cnt_q  <= bad_cnt_d;
            acq_cnt_q  <= acq_cnt_d;
            good_cgs_q <= good_cgs_d;
            loss_q     <= loss_d;
        end
    end

    assign SUDI             = sudi_q;
    assign code_sync_status = sync_q;
    assign rx_even          = rx_even_q;
    assign bad_cnt          = bad_cnt_q;
    assign loss_events      = loss_q;

endmodule

// File: doc/pcs_code_sync.md
PCS_CODE_SYNC -- requirements
Module: pcs_code_sync

Interface
REQ-001 SHALL have parameter ACQ_PAIRS, default 3: consecutive comma+data pairs required to acquire sync (>=1).
REQ-002 SHALL have parameter BAD_LIMIT, default 4: accumulated cgbad count that drops sync (>=1).
REQ-003 SHALL have parameter GOOD_LIMIT, default 4: consecutive cggood needed to retire one bad count (>=1).
REQ-004 SHALL have parameter CNT_W, default 16: width of the loss-event counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: ports clock (input, 1) and reset (input, 1, 0 = reset).
REQ-006 rx_code_group  input  10  received 10b code-group, one per clock.
REQ-007 signal_detect  input  1  PMD signal present; 0 forces loss of sync.
REQ-008 SUDI  output  10  rx_code_group delayed one clock.
REQ-009 code_sync_status  output  1  1 = synchronized.
REQ-010 rx_even  output  1  even/odd code-group position flag.
REQ-011 bad_cnt  output  clog2(BAD_LIMIT+1)  current accumulated bad count.
REQ-012 loss_events  output  CNT_W  number of sync-lost events, saturating.

Function
REQ-013 Classification SHALL be: comma = K28.5 either disparity; cgbad = invalid OR (comma AND rx_even==1); cggood = NOT cgbad.
REQ-014 States SHALL be LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED and SYNC_RECOVER, with all outputs registered.
REQ-015 signal_detect==0 in any state SHALL force LOSS_OF_SYNC on the next edge, clear acq_cnt, bad_cnt and good_cgs, and override all other transitions.
REQ-016 LOSS_OF_SYNC: comma -> COMMA_DETECT with rx_even<=1 and acq_cnt<=0; otherwise stay.
REQ-017 COMMA_DETECT: data -> if acq_cnt==ACQ_PAIRS-1 then SYNC_ACQUIRED, else ACQUIRE_SYNC with acq_cnt+1; non-data -> LOSS_OF_SYNC.
REQ-018 ACQUIRE_SYNC: (rx_even==0 AND comma) -> COMMA_DETECT with rx_even<=1; else cgbad -> LOSS_OF_SYNC; else stay.
REQ-019 SYNC_ACQUIRED: cggood -> stay; cgbad -> SYNC_RECOVER with bad_cnt<=1 and good_cgs<=0 (when BAD_LIMIT==1, -> LOSS_OF_SYNC instead).
REQ-020 SYNC_RECOVER: cgbad with bad_cnt==BAD_LIMIT-1 -> LOSS_OF_SYNC; other cgbad -> bad_cnt+1 and good_cgs<=0.
REQ-021 SYNC_RECOVER: cggood with good_cgs==GOOD_LIMIT-1 -> bad_cnt-1 and good_cgs<=0, and if the new bad_cnt==0 -> SYNC_ACQUIRED; other cggood -> good_cgs+1.
REQ-022 rx_even SHALL toggle every clock, except when set to 1 per REQ-016 and REQ-018.
REQ-023 code_sync_status SHALL be 1 exactly when state is SYNC_ACQUIRED or SYNC_RECOVER, visible the clock after the transition edge.
REQ-024 loss_events SHALL increment once per transition from SYNC_ACQUIRED or SYNC_RECOVER to LOSS_OF_SYNC (either cause) and hold at 2^CNT_W-1.
REQ-025 SUDI SHALL equal rx_code_group of the previous clock in every state.

Reset
REQ-026 reset==0 SHALL asynchronously set state LOSS_OF_SYNC and clear SUDI, code_sync_status, rx_even, bad_cnt, acq_cnt, good_cgs and loss_events to 0.
REQ-027 Reset asserted mid-operation SHALL abort any acquisition or recovery; after release, resynchronization SHALL require a full ACQ_PAIRS sequence.

Structure
REQ-028 Package pcs_pkg SHALL hold the K28.5 and D16.2 constants, the state encoding and the is_comma/is_data/is_valid/cggood/cgbad functions.
REQ-029 Decode SHALL be isolated in combinational sub-module pcs_cg_classify (outputs comma, data, valid); all counters and the FSM stay in pcs_code_sync.

Verification
REQ-030 Reset, signal_detect=1, then three /I2/ pairs (K28.5=0011111010, D16.2=1001000101) -> code_sync_status=1 the clock after the third D16.2; loss_events=0.
REQ-031 In sync, one invalid group 0000000000 followed by 4 IDLE pairs -> bad_cnt 1 then 0, state back in SYNC_ACQUIRED, code_sync_status stays 1.
REQ-032 In sync, 4 invalid groups spaced by fewer than 4 good groups -> code_sync_status=0 and loss_events=1.
REQ-033 K28.5 arriving with rx_even==1 during ACQUIRE_SYNC -> LOSS_OF_SYNC, acquisition restarts at acq_cnt 0.
REQ-034 signal_detect pulsed to 0 for one clock while synced, then restored with IDLE traffic -> immediate loss, loss_events+1, reacquired after 3 pairs.
REQ-035 Asynchronous reset asserted between clock edges during SYNC_RECOVER -> all outputs 0 before the next edge; with CNT_W=2, 5 forced losses -> loss_events=3.
